// File: rtl/pong_mem_copy_master.sv
// pong_mem_copy_master
//   Avalon-MM master that copies or fills blocks of words in the on-chip
//   memory shared with the Nios data master. Accesses are sequenced to the
//   slave's fixed one-cycle read latency: a copy spends READ / CAPTURE /
//   WRITE per word, a fill writes one word per cycle.
//
// Ports
//   clk, reset     : system clock, asynchronous active-high reset
//   start, mode    : command strobe (sampled only in IDLE), 0 = copy, 1 = fill
//   src_addr       : source word address (copy)
//   dst_addr       : destination word address
//   length         : word count, 0 .. 2^ADDR_W
//   fill_data      : fill pattern (fill)
//   busy, done     : status to the control register block (done is a pulse)
//   m_*            : Avalon-MM master towards the single-port memory slave
//   m_readdata     : unregistered slave read data, valid the cycle after READ
module pong_mem_copy_master #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] m_address,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_CAPTURE = 3'd2,
      S_WRITE   = 3'd3,
      S_FILL    = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

   state_t            state_r;
   logic [ADDR_W-1:0] src_ptr_r;
   logic [ADDR_W-1:0] dst_ptr_r;
   logic [ADDR_W:0]   remain_r;

   // Full byte lanes on every access; the block only moves whole words.
   assign m_byteenable = 4'hF;

   // Transfer sequencer. Every bus output is loaded on the edge that enters
   // the state it belongs to, so the outputs are pure registers. m_writedata
   // doubles as the copy data register and as the latched fill pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         src_ptr_r    <= {ADDR_W{1'b0}};
         dst_ptr_r    <= {ADDR_W{1'b0}};
         remain_r     <= CNT_ZERO;
         busy         <= 1'b0;
         done         <= 1'b0;
         m_address    <= {ADDR_W{1'b0}};
         m_chipselect <= 1'b0;
         m_write      <= 1'b0;
         m_writedata  <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               done         <= 1'b0;
               busy         <= 1'b0;
               m_chipselect <= 1'b0;
               m_write      <= 1'b0;
               if (start) begin
                  src_ptr_r <= src_addr;
                  dst_ptr_r <= dst_addr;
                  remain_r  <= length;
                  if (length == CNT_ZERO) begin
                     state_r <= S_DONE;
                     done    <= 1'b1;
                  end else if (mode == 1'b0) begin
                     state_r      <= S_READ;
                     busy         <= 1'b1;
                     m_chipselect <= 1'b1;
                     m_write      <= 1'b0;
                     m_address    <= src_addr;
                  end else begin
                     state_r      <= S_FILL;
                     busy         <= 1'b1;
                     m_chipselect <= 1'b1;
                     m_write      <= 1'b1;
                     m_address    <= dst_addr;
                     m_writedata  <= fill_data;
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end

            S_READ: begin
               // Slave registers the read address at the end of this cycle.
               state_r      <= S_CAPTURE;
               m_chipselect <= 1'b0;
               m_write      <= 1'b0;
            end

            S_CAPTURE: begin
               // m_readdata is valid only now; grab it as the write data.
               state_r      <= S_WRITE;
               m_chipselect <= 1'b1;
               m_write      <= 1'b1;
               m_address    <= dst_ptr_r;
               m_writedata  <= m_readdata;
            end

            S_WRITE: begin
               src_ptr_r <= src_ptr_r + PTR_ONE;
               dst_ptr_r <= dst_ptr_r + PTR_ONE;
               remain_r  <= remain_r - CNT_ONE;
               if (remain_r == CNT_ONE) begin
                  state_r      <= S_DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  m_chipselect <= 1'b0;
                  m_write      <= 1'b0;
               end else begin
                  state_r      <= S_READ;
                  m_chipselect <= 1'b1;
                  m_write      <= 1'b0;
                  m_address    <= src_ptr_r + PTR_ONE;
               end
            end

            S_FILL: begin
               dst_ptr_r <= dst_ptr_r + PTR_ONE;
               remain_r  <= remain_r - CNT_ONE;
               if (remain_r == CNT_ONE) begin
                  state_r      <= S_DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  m_chipselect <= 1'b0;
                  m_write      <= 1'b0;
               end else begin
                  state_r   <= S_FILL;
                  m_address <= dst_ptr_r + PTR_ONE;
               end
            end

            S_DONE: begin
               // A start seen here is dropped: commands are sampled in IDLE only.
               state_r      <= S_IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               m_chipselect <= 1'b0;
               m_write      <= 1'b0;
            end

            default: begin
               state_r      <= S_IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               m_chipselect <= 1'b0;
               m_write      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_mem_copy_master.sv
`timescale 1ns/1ps
module tb_pong_mem_copy_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [9:0]  src_addr = 10'd0;
   logic [9:0]  dst_addr = 10'd0;
   logic [10:0] length = 11'd0;
   logic [31:0] fill_data = 32'd0;
   logic        busy, done;
   logic [9:0]  m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = 32'd0;

   int tests = 0;
   int fails = 0;

   pong_mem_copy_master #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .busy(busy), .done(done),
      .m_address(m_address), .m_byteenable(m_byteenable),
      .m_chipselect(m_chipselect), .m_write(m_write),
      .m_writedata(m_writedata), .m_readdata(m_readdata)
   );

   always #5 clk = ~clk;

   // Slave memory: synchronous single-port RAM with one-cycle read latency.
   logic [31:0] mem [0:1023];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_addr = 10'd0;
   logic [31:0] poke_data = 32'd0;

   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (m_chipselect && m_write) mem[m_address] <= m_writedata;
      if (m_chipselect && !m_write) m_readdata <= mem[m_address];
   end

   // Reference memory: what the memory should hold after each operation.
   logic [31:0] ref_mem [0:1023];

   typedef struct {
      logic        md;
      int          s;
      int          d;
      int          n;
      logic [31:0] f;
      int          exp_done;
      bit          mid;
      bit          at_done;
      int          pre_a;
      int          pre_n;
      logic [31:0] pre_v;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 1024; i++) begin
         if (mem[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s: %0d words differ, first at %0h got %0h expected %0h",
                  name, bad, first, mem[first], ref_mem[first]);
      end
   endtask

   task automatic poke(input int a, input logic [31:0] v);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_addr = 10'(a);
      poke_data = v;
      ref_mem[a] = v;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic drive_junk();
      start     = 1'b1;
      mode      = 1'($urandom);
      src_addr  = 10'($urandom);
      dst_addr  = 10'($urandom);
      length    = 11'($urandom_range(1, 8));
      fill_data = $urandom;
   endtask

   // One operation: model update, command, cycle-by-cycle observation, checks.
   task automatic run_op(input string name, input logic md, input int s, input int d,
                         input int n, input logic [31:0] f, input int exp_done,
                         input bit inj_mid, input bit inj_done);
      int done_at = 0;
      int done_cnt = 0;
      int busy_cnt = 0;
      int cs_cnt = 0;
      int stray = 0;
      for (int k = 0; k < n; k++) begin
         if (md) ref_mem[(d + k) % 1024] = f;
         else    ref_mem[(d + k) % 1024] = ref_mem[(s + k) % 1024];
      end
      @(negedge clk);
      start     = 1'b1;
      mode      = md;
      src_addr  = 10'(s);
      dst_addr  = 10'(d);
      length    = 11'(n);
      fill_data = f;
      @(posedge clk);
      for (int cyc = 1; cyc <= 3200; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cnt++;
         if (m_chipselect) cs_cnt++;
         if (m_chipselect && !busy) stray++;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = cyc;
            if (inj_done) drive_junk();
         end
         if (inj_mid && cyc == 5) drive_junk();
         if (done_at != 0 && cyc >= done_at + 4) break;
      end
      check({name, " done_cycle"}, 64'(done_at), 64'(exp_done));
      check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
      check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
      check({name, " bus_cycles"}, 64'(cs_cnt), 64'(md ? n : 2 * n));
      check({name, " cs_outside_busy"}, 64'(stray), 64'd0);
      check({name, " byteenable"}, 64'(m_byteenable), 64'hF);
      check_mem({name, " memory"});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 0,     0,     1024, 32'h5A5A0001, 1025, 1'b0, 1'b0, 0,     0, 32'h0};
      vecs[1] = '{1'b0, 'h010, 'h100, 4,    32'h0,        13,   1'b0, 1'b0, 'h010, 4, 32'hA0};
      vecs[2] = '{1'b1, 0,     'h3FE, 4,    32'hDEADBEEF, 5,    1'b0, 1'b0, 0,     0, 32'h0};
      vecs[3] = '{1'b0, 'h020, 'h030, 0,    32'h0,        1,    1'b0, 1'b0, 0,     0, 32'h0};
      vecs[4] = '{1'b0, 0,     1,     3,    32'h0,        10,   1'b0, 1'b0, 0,     4, 32'h1};
      vecs[5] = '{1'b0, 'h200, 'h280, 4,    32'h0,        13,   1'b1, 1'b0, 0,     0, 32'h0};
      vecs[6] = '{1'b0, 'h300, 'h310, 2,    32'h0,        7,    1'b0, 1'b1, 0,     0, 32'h0};
      vecs[7] = '{1'b1, 0,     'h3FF, 1,    32'h12345678, 2,    1'b0, 1'b0, 0,     0, 32'h0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst cs", 64'(m_chipselect), 64'd0);
      check("rst write", 64'(m_write), 64'd0);
      check("rst addr", 64'(m_address), 64'd0);
      check("rst wdata", 64'(m_writedata), 64'd0);
      check("rst be", 64'(m_byteenable), 64'hF);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 1024; i++) poke(i, $urandom);

      // Directed table.
      for (int v = 0; v < 8; v++) begin
         for (int p = 0; p < vecs[v].pre_n; p++)
            poke(vecs[v].pre_a + p, vecs[v].pre_v + 32'(p));
         run_op($sformatf("vec%0d", v), vecs[v].md, vecs[v].s, vecs[v].d, vecs[v].n,
                vecs[v].f, vecs[v].exp_done, vecs[v].mid, vecs[v].at_done);
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("copy word %0d", i), 64'(mem[256 + i]), 64'(32'hA0 + 32'(i)));
         check($sformatf("smear word %0d", i), 64'(mem[i]), 64'd1);
      end
      check("fill wrap 3FE", 64'(mem[1022]), 64'hDEADBEEF);
      check("fill 3FF", 64'(mem[1023]), 64'h12345678);

      // Randomized operations against the reference memory.
      for (int r = 0; r < 20; r++) begin
         logic md;
         int s, d, n;
         md = 1'($urandom);
         s  = $urandom_range(0, 1023);
         d  = $urandom_range(0, 1023);
         n  = $urandom_range(0, 40);
         run_op($sformatf("rand%0d", r), md, s, d, n, $urandom,
                (n == 0) ? 1 : (md ? n + 1 : 3 * n + 1), 1'b0, 1'b0);
      end

      // Reset during the WRITE of word 2 of a 4-word copy 0x40 -> 0x50.
      for (int k = 0; k < 2; k++) ref_mem[80 + k] = ref_mem[64 + k];
      @(negedge clk);
      start    = 1'b1;
      mode     = 1'b0;
      src_addr = 10'h040;
      dst_addr = 10'h050;
      length   = 11'd4;
      @(posedge clk);
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("mid write strobes", 64'({busy, m_chipselect, m_write}), 64'b111);
      check("mid write addr", 64'(m_address), 64'h052);
      check("mid write data", 64'(m_writedata), 64'(ref_mem[66]));
      reset = 1'b1;
      #1;
      check("arst busy", 64'(busy), 64'd0);
      check("arst done", 64'(done), 64'd0);
      check("arst cs", 64'(m_chipselect), 64'd0);
      check("arst write", 64'(m_write), 64'd0);
      check("arst addr", 64'(m_address), 64'd0);
      check("arst wdata", 64'(m_writedata), 64'd0);
      check("arst be", 64'(m_byteenable), 64'hF);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_mem("after reset memory");
      run_op("post reset copy", 1'b0, 'h040, 'h060, 3, 32'h0, 10, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
